mem_port_arbiter: RTL and testbench

- Parametrised N-port arbiter that merges several core-side memory requesters (instruction fetch, data, future DMA/debug) onto one downstream memory port.
- Uses the same start/ready/rdata_valid handshake the core pipeline stages already use.
- Each port has a one-deep command slot, so simultaneous requests are buffered rather than dropped.
- One downstream transaction is in flight at a time; the arbitration mode is selectable.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter family.
//   arb_state_e  - downstream transaction FSM states
//   ARB_FIXED    - lowest pending index wins
//   ARB_RR       - round-robin starting at the rotating pointer
//   grant_width  - width of a port index, never less than 1 bit
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } arb_state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    function automatic int unsigned grant_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection over a pending vector.
//   pending     - request bits, one per port
//   ptr         - round-robin start index (ignored in fixed mode)
//   rr_mode     - 1 = round-robin, 0 = fixed priority (lowest index)
//   winner      - selected index, 0 when nothing is pending
//   any_pending - at least one request bit is set
module rr_picker #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [IDX_W-1:0]     ptr,
    input  logic                 rr_mode,
    output logic [IDX_W-1:0]     winner,
    output logic                 any_pending
);

    logic [IDX_W-1:0] lowest_any;
    logic [IDX_W-1:0] lowest_hi;
    logic             found_hi;

    // Scanning downwards leaves the lowest matching index as the last assignment.
    // lowest_hi is the first request at or after ptr; if none, wrap to lowest_any.
    always_comb begin
        lowest_any = '0;
        lowest_hi  = '0;
        found_hi   = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lowest_any = IDX_W'(i);
                if (i >= int'(ptr)) begin
                    lowest_hi = IDX_W'(i);
                    found_hi  = 1'b1;
                end
            end
        end
    end

    assign winner      = (rr_mode && found_hi) ? lowest_hi : lowest_any;
    assign any_pending = |pending;

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter merging core-side requesters onto one downstream memory port.
// Each port owns a one-deep command slot; one downstream transaction at a time.
//   clk, rst_n            - clock, asynchronous active-low reset
//   p_cmd_*/p_addr/...    - per-port command inputs (packed), ready = slot free
//   p_rdata/p_rdata_valid - shared read data, one-hot one-cycle qualifier
//   mem_*                 - downstream command/response handshake
//   grant_id              - index of the current or last granted port
//   busy                  - FSM is not IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ARB_MODE   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              p_cmd_start,
    input  logic [NUM_PORTS-1:0]              p_cmd_write,
    output logic [NUM_PORTS-1:0]              p_cmd_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   p_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   p_wmask,
    output logic [DATA_WIDTH-1:0]             p_rdata,
    output logic [NUM_PORTS-1:0]              p_rdata_valid,
    output logic                              mem_cmd_start,
    output logic                              mem_cmd_write,
    input  logic                              mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH-1:0]             mem_wmask,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_rdata_valid,
    output logic [grant_width(NUM_PORTS)-1:0] grant_id,
    output logic                              busy
);

    localparam int unsigned   GW       = grant_width(NUM_PORTS);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_PORTS - 1);

    arb_state_e state_q, state_d;

    logic [NUM_PORTS-1:0]  pending_q, pending_d, capture;
    logic [NUM_PORTS-1:0]  slot_write_q;
    logic [ADDR_WIDTH-1:0] slot_addr_q  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] slot_wdata_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] slot_wmask_q [NUM_PORTS];

    logic [GW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner;
    logic          any_pending;

    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] mem_wmask_q, mem_wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]  rdata_valid_q, rdata_valid_d;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (GW)
    ) u_picker (
        .pending     (pending_q),
        .ptr         (rr_ptr_q),
        .rr_mode     (ARB_MODE == ARB_RR),
        .winner      (winner),
        .any_pending (any_pending)
    );

    assign capture = p_cmd_start & ~pending_q;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q | capture;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        rdata_d       = rdata_q;
        rdata_valid_d = '0;
        mem_cmd_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Picks from slots captured on earlier edges only.
                if (any_pending) begin
                    grant_d     = winner;
                    mem_write_d = slot_write_q[winner];
                    mem_addr_d  = slot_addr_q[winner];
                    mem_wdata_d = slot_wdata_q[winner];
                    mem_wmask_d = slot_wmask_q[winner];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mem_cmd_start = mem_cmd_ready;
                if (mem_cmd_ready) begin
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    if (mem_write_q) begin
                        pending_d[grant_q] = 1'b0;
                        state_d            = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rdata_valid) begin
                    rdata_d                = mem_rdata;
                    rdata_valid_d[grant_q] = 1'b1;
                    pending_d[grant_q]     = 1'b0;
                    state_d                = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_write_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                slot_wmask_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (capture[i]) begin
                    slot_write_q[i] <= p_cmd_write[i];
                    slot_addr_q[i]  <= p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_wdata_q[i] <= p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    slot_wmask_q[i] <= p_wmask[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign p_cmd_ready   = ~pending_q;
    assign p_rdata       = rdata_q;
    assign p_rdata_valid = rdata_valid_q;
    assign mem_cmd_write = mem_write_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 4-port round-robin instance (a_*) and a
// 2-port fixed-priority instance (b_*), checked against a command scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]      a_start, a_write, a_ready, a_rvalid;
    logic [4*AW-1:0] a_addr;
    logic [4*DW-1:0] a_wdata, a_wmask;
    logic [DW-1:0]   a_rdata, a_mwdata, a_mwmask, a_mrdata;
    logic [AW-1:0]   a_maddr;
    logic            a_mstart, a_mwrite, a_mready, a_mrvalid, a_busy;
    logic [1:0]      a_grant;

    logic [1:0]      b_start, b_write, b_ready, b_rvalid;
    logic [2*AW-1:0] b_addr;
    logic [2*DW-1:0] b_wdata, b_wmask;
    logic [DW-1:0]   b_rdata, b_mwdata, b_mwmask, b_mrdata;
    logic [AW-1:0]   b_maddr;
    logic            b_mstart, b_mwrite, b_mready, b_mrvalid, b_busy;
    logic [0:0]      b_grant;

    mem_port_arbiter #(
        .NUM_PORTS (4), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ARB_MODE (1)
    ) u_dut_rr (
        .clk (clk), .rst_n (rst_n),
        .p_cmd_start (a_start), .p_cmd_write (a_write), .p_cmd_ready (a_ready),
        .p_addr (a_addr), .p_wdata (a_wdata), .p_wmask (a_wmask),
        .p_rdata (a_rdata), .p_rdata_valid (a_rvalid),
        .mem_cmd_start (a_mstart), .mem_cmd_write (a_mwrite), .mem_cmd_ready (a_mready),
        .mem_addr (a_maddr), .mem_wdata (a_mwdata), .mem_wmask (a_mwmask),
        .mem_rdata (a_mrdata), .mem_rdata_valid (a_mrvalid),
        .grant_id (a_grant), .busy (a_busy)
    );

    mem_port_arbiter #(
        .NUM_PORTS (2), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ARB_MODE (0)
    ) u_dut_fx (
        .clk (clk), .rst_n (rst_n),
        .p_cmd_start (b_start), .p_cmd_write (b_write), .p_cmd_ready (b_ready),
        .p_addr (b_addr), .p_wdata (b_wdata), .p_wmask (b_wmask),
        .p_rdata (b_rdata), .p_rdata_valid (b_rvalid),
        .mem_cmd_start (b_mstart), .mem_cmd_write (b_mwrite), .mem_cmd_ready (b_mready),
        .mem_addr (b_maddr), .mem_wdata (b_mwdata), .mem_wmask (b_mwmask),
        .mem_rdata (b_mrdata), .mem_rdata_valid (b_mrvalid),
        .grant_id (b_grant), .busy (b_busy)
    );

    typedef struct {
        int            port;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
    } cmd_t;

    cmd_t          a_q[$];
    cmd_t          b_q[$];
    logic [DW-1:0] rd_q[$];
    logic [3:0]    a_pend;
    logic [1:0]    b_pend;
    int            checks   = 0;
    int            failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t mk_cmd(input int p, input logic wr, input logic [AW-1:0] ad);
        cmd_t c;
        c.port  = p;
        c.wr    = wr;
        c.addr  = ad;
        c.wdata = {ad[15:0], ad[31:16]} ^ 32'hCAFE_0000;
        c.wmask = ~ad;
        return c;
    endfunction

    task automatic a_cmd(input int p, input logic wr, input logic [AW-1:0] ad);
        cmd_t c = mk_cmd(p, wr, ad);
        a_start[p]          = 1'b1;
        a_write[p]          = wr;
        a_addr[p*AW +: AW]  = c.addr;
        a_wdata[p*DW +: DW] = c.wdata;
        a_wmask[p*DW +: DW] = c.wmask;
        a_pend[p]           = 1'b1;
        a_q.push_back(c);
    endtask

    task automatic b_cmd(input int p, input logic wr, input logic [AW-1:0] ad);
        cmd_t c = mk_cmd(p, wr, ad);
        b_start[p]          = 1'b1;
        b_write[p]          = wr;
        b_addr[p*AW +: AW]  = c.addr;
        b_wdata[p*DW +: DW] = c.wdata;
        b_wmask[p*DW +: DW] = c.wmask;
        b_pend[p]           = 1'b1;
        b_q.push_back(c);
    endtask

    // Serve n queued write commands on the round-robin instance.
    task automatic a_serve(input int n);
        for (int k = 0; k < n; k++) begin
            int   w = 0;
            cmd_t e;
            while (a_mstart !== 1'b1 && w < 40) begin
                step();
                w++;
            end
            checks++;
            if (a_mstart !== 1'b1 || a_q.size() == 0) begin
                failures++;
                $display("FAIL a_issue: mem_cmd_start=%b queued=%0d required start with queued cmd",
                         a_mstart, a_q.size());
                return;
            end
            e = a_q.pop_front();
            checks++;
            if (a_grant !== 2'(e.port) || a_mwrite !== e.wr || a_maddr !== e.addr ||
                a_mwdata !== e.wdata || a_mwmask !== e.wmask) begin
                failures++;
                $display("FAIL a_cmd: got port=%0d wr=%b addr=%h wd=%h wm=%h required port=%0d wr=%b addr=%h wd=%h wm=%h",
                         a_grant, a_mwrite, a_maddr, a_mwdata, a_mwmask,
                         e.port, e.wr, e.addr, e.wdata, e.wmask);
            end
            a_pend[e.port] = 1'b0;
            step();
            checks++;
            if (a_ready !== ~a_pend) begin
                failures++;
                $display("FAIL a_ready: got %b required %b", a_ready, ~a_pend);
            end
        end
    endtask

    task automatic b_serve(input int n);
        for (int k = 0; k < n; k++) begin
            int   w = 0;
            cmd_t e;
            while (b_mstart !== 1'b1 && w < 40) begin
                step();
                w++;
            end
            checks++;
            if (b_mstart !== 1'b1 || b_q.size() == 0) begin
                failures++;
                $display("FAIL b_issue: mem_cmd_start=%b queued=%0d required start with queued cmd",
                         b_mstart, b_q.size());
                return;
            end
            e = b_q.pop_front();
            checks++;
            if (b_grant !== 1'(e.port) || b_mwrite !== e.wr || b_maddr !== e.addr ||
                b_mwdata !== e.wdata || b_mwmask !== e.wmask) begin
                failures++;
                $display("FAIL b_cmd: got port=%0d addr=%h wd=%h wm=%h required port=%0d addr=%h wd=%h wm=%h",
                         b_grant, b_maddr, b_mwdata, b_mwmask, e.port, e.addr, e.wdata, e.wmask);
            end
            b_pend[e.port] = 1'b0;
            step();
            checks++;
            if (b_ready !== ~b_pend) begin
                failures++;
                $display("FAIL b_ready: got %b required %b", b_ready, ~b_pend);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (a_ready !== 4'hF || a_rvalid !== 4'h0 || a_rdata !== '0 || a_mstart !== 1'b0 ||
            a_maddr !== '0 || a_mwdata !== '0 || a_mwmask !== '0 || a_mwrite !== 1'b0 ||
            a_grant !== 2'd0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: rdy=%b rv=%b rd=%h st=%b ad=%h wd=%h wm=%h wr=%b g=%0d busy=%b required rdy=1111 rest 0",
                     a_ready, a_rvalid, a_rdata, a_mstart, a_maddr, a_mwdata, a_mwmask,
                     a_mwrite, a_grant, a_busy);
        end
        checks++;
        if (b_ready !== 2'b11 || b_rvalid !== 2'b00 || b_rdata !== '0 || b_mstart !== 1'b0 ||
            b_maddr !== '0 || b_mwrite !== 1'b0 || b_grant !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: rdy=%b rv=%b rd=%h st=%b ad=%h g=%0d busy=%b required rdy=11 rest 0",
                     b_ready, b_rvalid, b_rdata, b_mstart, b_maddr, b_grant, b_busy);
        end
        rst_n = 1'b1;
        step();
        // Stray read data while IDLE must be ignored.
        a_mrvalid = 1'b1;
        a_mrdata  = 32'h5555_AAAA;
        step();
        a_mrvalid = 1'b0;
        checks++;
        if (a_rvalid !== 4'h0 || a_busy !== 1'b0 || a_rdata !== '0) begin
            failures++;
            $display("FAIL idle_rvalid: rv=%b busy=%b rd=%h required rv=0000 busy=0 rd=0",
                     a_rvalid, a_busy, a_rdata);
        end
    endtask

    task automatic test_single_read();
        cmd_t          e;
        logic [DW-1:0] exp_rd;
        a_cmd(0, 1'b0, 32'h0000_0100);
        step();
        a_start = '0;
        checks++;
        if (a_mstart !== 1'b0 || a_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL rd_c1: start=%b ready0=%b required start=0 ready0=0", a_mstart, a_ready[0]);
        end
        step();
        checks++;
        if (a_mstart !== 1'b1) begin
            failures++;
            $display("FAIL rd_latency: mem_cmd_start=%b required 1 two cycles after start", a_mstart);
        end
        e = a_q.pop_front();
        checks++;
        if (a_grant !== 2'(e.port) || a_mwrite !== 1'b0 || a_maddr !== e.addr) begin
            failures++;
            $display("FAIL rd_cmd: port=%0d wr=%b addr=%h required port=%0d wr=0 addr=%h",
                     a_grant, a_mwrite, a_maddr, e.port, e.addr);
        end
        step();
        step();
        step();
        a_mrvalid = 1'b1;
        a_mrdata  = 32'hDEAD_BEEF;
        rd_q.push_back(32'hDEAD_BEEF);
        checks++;
        if (a_rvalid !== 4'h0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL rd_early: rv=%b busy=%b required rv=0000 busy=1", a_rvalid, a_busy);
        end
        step();
        a_mrvalid = 1'b0;
        a_mrdata  = '0;
        exp_rd    = rd_q.pop_front();
        a_pend[0] = 1'b0;
        checks++;
        if (a_rvalid !== 4'b0001 || a_rdata !== exp_rd) begin
            failures++;
            $display("FAIL rd_data: rv=%b rdata=%h required rv=0001 rdata=%h", a_rvalid, a_rdata, exp_rd);
        end
        checks++;
        if (a_ready !== ~a_pend || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_ready: ready=%b busy=%b required ready=%b busy=0", a_ready, a_busy, ~a_pend);
        end
        step();
        checks++;
        if (a_rvalid !== 4'h0) begin
            failures++;
            $display("FAIL rd_pulse: rv=%b required 0000 after one cycle", a_rvalid);
        end
    endtask

    task automatic test_rr_simultaneous();
        int ord[4] = '{2, 3, 0, 1};
        // Serving port 1 leaves the pointer at 2.
        a_cmd(1, 1'b1, 32'h0000_0200);
        step();
        a_start = '0;
        a_serve(1);
        for (int k = 0; k < 4; k++) a_cmd(ord[k], 1'b1, 32'(16 * ord[k]));
        step();
        a_start = '0;
        checks++;
        if (a_ready !== 4'h0) begin
            failures++;
            $display("FAIL all_captured: ready=%b required 0000", a_ready);
        end
        a_serve(4);
    endtask

    task automatic test_fixed_vs_rr();
        for (int r = 0; r < 3; r++) begin
            b_cmd(0, 1'b1, 32'(32'h40 + r));
            step();
            b_start = '0;
            b_serve(1);
            b_cmd(0, 1'b1, 32'(32'h80 + r));
            b_cmd(1, 1'b1, 32'(32'h90 + r));
            step();
            b_start = '0;
            b_serve(2);
        end
        // Round-robin pointer sits at 1 after port 0 alone, so port 1 goes first.
        for (int r = 0; r < 3; r++) begin
            a_cmd(0, 1'b1, 32'(32'h140 + r));
            step();
            a_start = '0;
            a_serve(1);
            a_cmd(1, 1'b1, 32'(32'h190 + r));
            a_cmd(0, 1'b1, 32'(32'h180 + r));
            step();
            a_start = '0;
            a_serve(2);
        end
    endtask

    task automatic test_back_pressure();
        int bad    = 0;
        int starts = 0;
        a_mready = 1'b0;
        a_cmd(2, 1'b1, 32'h0000_0BB0);
        step();
        a_start = '0;
        step();
        for (int k = 0; k < 20; k++) begin
            if (a_mstart !== 1'b0 || a_maddr !== 32'h0000_0BB0 || a_busy !== 1'b1 ||
                a_grant !== 2'd2) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL back_pressure: %0d unstable cycles required 0", bad);
        end
        a_mready = 1'b1;
        #1;
        a_serve(1);
        for (int k = 0; k < 5; k++) begin
            if (a_mstart === 1'b1) starts++;
            step();
        end
        checks++;
        if (starts != 0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_start: extra starts=%0d busy=%b required 0 and 0", starts, a_busy);
        end
    endtask

    task automatic test_ignored_start();
        int starts = 0;
        a_mready = 1'b0;
        a_cmd(1, 1'b1, 32'h0000_0C10);
        step();
        a_start[1]          = 1'b1;
        a_addr[1*AW +: AW]  = 32'h0000_0DD0;
        checks++;
        if (a_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL ign_ready: ready1=%b required 0", a_ready[1]);
        end
        step();
        a_start = '0;
        step();
        a_mready = 1'b1;
        #1;
        a_serve(1);
        for (int k = 0; k < 6; k++) begin
            if (a_mstart === 1'b1) starts++;
            step();
        end
        checks++;
        if (starts != 0) begin
            failures++;
            $display("FAIL ign_extra: extra starts=%0d required 0", starts);
        end
    endtask

    task automatic test_reset_in_wait_rd();
        int   w   = 0;
        int   bad = 0;
        cmd_t e;
        a_cmd(3, 1'b0, 32'h0000_0300);
        step();
        a_start = '0;
        while (a_mstart !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        e = a_q.pop_front();
        checks++;
        if (a_mstart !== 1'b1 || a_maddr !== e.addr || a_grant !== 2'd3) begin
            failures++;
            $display("FAIL rst_rd_issue: start=%b addr=%h g=%0d required 1 %h 3",
                     a_mstart, a_maddr, a_grant, e.addr);
        end
        step();
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_rd_busy: busy=%b required 1 in WAIT_RD", a_busy);
        end
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        a_pend    = '0;
        a_mrvalid = 1'b1;
        a_mrdata  = 32'h1234_5678;
        step();
        a_mrvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (a_rvalid !== 4'h0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || a_ready !== 4'hF || a_busy !== 1'b0 || a_grant !== 2'd0) begin
            failures++;
            $display("FAIL rst_rd: rvalid cycles=%0d ready=%b busy=%b g=%0d required 0 1111 0 0",
                     bad, a_ready, a_busy, a_grant);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        a_start   = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_wmask = '0;
        a_mready  = 1'b1; a_mrdata = '0; a_mrvalid = 1'b0;
        b_start   = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_wmask = '0;
        b_mready  = 1'b1; b_mrdata = '0; b_mrvalid = 1'b0;
        a_pend    = '0;
        b_pend    = '0;
        test_reset();
        test_single_read();
        test_rr_simultaneous();
        test_fixed_vs_rr();
        test_back_pressure();
        test_ignored_start();
        test_reset_in_wait_rd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
